// File: rtl/cvxif_offload_unit.sv
// Offload unit: hands one instruction at a time to a CV-X-IF coprocessor and
// returns its result, or an illegal/timeout error, to the core as a one-cycle writeback.
module cvxif_offload_unit #(
    parameter int XLEN          = 64,
    parameter int IdWidth       = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [31:0]          instr_i,
    input  logic [2*XLEN-1:0]    rs_i,
    input  logic [IdWidth-1:0]   id_i,
    input  logic                 flush_i,
    output logic                 issue_valid_o,
    output logic [31:0]          issue_instr_o,
    output logic [IdWidth-1:0]   issue_id_o,
    output logic [2*XLEN-1:0]    issue_rs_o,
    input  logic                 issue_ready_i,
    input  logic                 issue_accept_i,
    output logic                 commit_valid_o,
    output logic                 commit_kill_o,
    input  logic                 result_valid_i,
    output logic                 result_ready_o,
    input  logic [IdWidth-1:0]   result_id_i,
    input  logic [XLEN-1:0]      result_data_i,
    input  logic [4:0]           result_rd_i,
    input  logic                 result_we_i,
    output logic                 wb_valid_o,
    output logic [IdWidth-1:0]   wb_id_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic [4:0]           wb_rd_o,
    output logic                 wb_we_o,
    output logic [1:0]           wb_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, WAIT_RES} state_t;

    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    state_t              state;
    logic                pending_kill;
    logic [15:0]         timer;
    logic [31:0]         instr_q;
    logic [2*XLEN-1:0]   rs_q;
    logic [IdWidth-1:0]  id_q;
    logic                flush_seen;
    logic                result_hit;

    assign issue_instr_o = instr_q;
    assign issue_id_o    = id_q;
    assign issue_rs_o    = rs_q;
    // A flush arriving in the commit cycle itself still turns the commit into a kill.
    assign flush_seen    = pending_kill | flush_i;
    assign commit_kill_o = commit_valid_o & flush_seen;
    assign result_hit    = result_valid_i & (result_id_i == id_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= IDLE;
            pending_kill   <= 1'b0;
            timer          <= '0;
            instr_q        <= '0;
            rs_q           <= '0;
            id_q           <= '0;
            instr_ready_o  <= 1'b0;
            issue_valid_o  <= 1'b0;
            commit_valid_o <= 1'b0;
            result_ready_o <= 1'b0;
            wb_valid_o     <= 1'b0;
            wb_id_o        <= '0;
            wb_data_o      <= '0;
            wb_rd_o        <= '0;
            wb_we_o        <= 1'b0;
            wb_err_o       <= 2'b00;
        end else begin
            wb_valid_o <= 1'b0;
            wb_id_o    <= '0;
            wb_data_o  <= '0;
            wb_rd_o    <= '0;
            wb_we_o    <= 1'b0;
            wb_err_o   <= 2'b00;
            unique case (state)
                IDLE: begin
                    instr_ready_o <= 1'b1;
                    if (instr_ready_o && instr_valid_i && !flush_i) begin
                        instr_q       <= instr_i;
                        rs_q          <= rs_i;
                        id_q          <= id_i;
                        instr_ready_o <= 1'b0;
                        issue_valid_o <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush_i) begin
                        pending_kill <= 1'b1;
                    end
                    if (issue_ready_i) begin
                        issue_valid_o <= 1'b0;
                        if (issue_accept_i) begin
                            commit_valid_o <= 1'b1;
                            state          <= COMMIT;
                        end else begin
                            instr_ready_o <= 1'b1;
                            pending_kill  <= 1'b0;
                            state         <= IDLE;
                            if (!flush_seen) begin
                                wb_valid_o <= 1'b1;
                                wb_id_o    <= id_q;
                                wb_err_o   <= 2'b01;
                            end
                        end
                    end
                end
                COMMIT: begin
                    commit_valid_o <= 1'b0;
                    if (flush_seen) begin
                        instr_ready_o <= 1'b1;
                        pending_kill  <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        result_ready_o <= 1'b1;
                        timer          <= '0;
                        state          <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    // Priority: flush, then a matching result, then the timeout.
                    if (flush_i || result_hit || timer == TimeoutLast) begin
                        result_ready_o <= 1'b0;
                        instr_ready_o  <= 1'b1;
                        pending_kill   <= 1'b0;
                        state          <= IDLE;
                        if (!flush_i) begin
                            wb_valid_o <= 1'b1;
                            wb_id_o    <= id_q;
                            if (result_hit) begin
                                wb_data_o <= result_data_i;
                                wb_rd_o   <= result_rd_i;
                                wb_we_o   <= result_we_i;
                            end else begin
                                wb_err_o  <= 2'b10;
                            end
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule
